fifo_pixel_unpack: RTL and testbench



---
 rtl/fifo_pixel_unpack_pkg.sv | 12 +
 rtl/fifo_pixel_unpack.sv | 105 ++++++++++
 tb/tb_fifo_pixel_unpack.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pixel_unpack_pkg.sv
// Shared helpers for the pixel unpacker: width derivation for the word-index counter.
// Latency: n/a (package only, no logic).
// Backpressure: n/a.
package fifo_pixel_unpack_pkg;

  // Width of a counter that indexes PPW pixels within a word; never below 1 bit
  // so a one-pixel-per-word configuration still gets a legal vector.
  function automatic int pix_idx_width(input int ppw);
    return (ppw > 1) ? $clog2(ppw) : 1;
  endfunction

endpackage

// File: rtl/fifo_pixel_unpack.sv
// Unpacks WW-bit FIFO words into a PW-bit pixel stream with an end-of-line marker.
// Latency: FIFO word pops the cycle it appears (if nothing held); first pixel valid next cycle.
// Backpressure: while o_valid && !i_ready the pixel and o_last hold and no word is popped.
//
// Ports:
//   i_clk, i_reset_n         clock, asynchronous active-low reset
//   i_sync                   synchronous frame restart (drops held word, zeroes position)
//   i_line_pixels            pixels per line, 0 encodes 2^LGLINE; latched at line boundaries
//   i_fifo_empty/_data       FIFO asynchronous-read head; o_fifo_rd pops it
//   o_valid/i_ready          pixel handshake; o_pixel data, o_last marks end of line
module fifo_pixel_unpack
  import fifo_pixel_unpack_pkg::*;
#(
  parameter int WW     = 32,
  parameter int PW     = 8,
  parameter int LGLINE = 11
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_sync,
  input  logic [LGLINE-1:0] i_line_pixels,
  input  logic              i_fifo_empty,
  input  logic [WW-1:0]     i_fifo_data,
  output logic              o_fifo_rd,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [PW-1:0]     o_pixel,
  output logic              o_last
);

  localparam int PPW = WW / PW;
  localparam int IW  = pix_idx_width(PPW);
  localparam logic [IW-1:0] LAST_IDX = IW'(PPW - 1);

  if (((WW % PW) != 0) || (PPW < 1)) begin : g_bad_cfg
    $error("fifo_pixel_unpack: WW must be a non-zero integer multiple of PW");
  end

  logic [WW-1:0]     r_word;
  logic              r_valid;
  logic [IW-1:0]     r_widx;
  logic [LGLINE-1:0] r_xpos;
  logic [LGLINE-1:0] r_len;

  logic [LGLINE-1:0] len_m1;
  logic              accept;
  logic              last_px;
  logic              word_end;
  logic              line_end;

  // Modular subtraction makes r_len == 0 mean a full 2^LGLINE-pixel line.
  assign len_m1   = r_len - LGLINE'(1);
  assign last_px  = r_valid && (r_xpos == len_m1);
  assign accept   = r_valid && i_ready;
  // A line end also ends the word: every line starts on a word boundary.
  assign word_end = accept && ((r_widx == LAST_IDX) || last_px);
  assign line_end = accept && last_px;

  // Popping in the same cycle as the final accept keeps the stream bubble-free.
  assign o_fifo_rd = i_reset_n && !i_fifo_empty && !i_sync && (!r_valid || word_end);

  assign o_valid = r_valid;
  assign o_pixel = r_word[PW-1:0];
  assign o_last  = last_px;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_word  <= '0;
      r_valid <= 1'b0;
      r_widx  <= '0;
      r_xpos  <= '0;
      r_len   <= '0;
    end else if (i_sync) begin
      r_valid <= 1'b0;
      r_widx  <= '0;
      r_xpos  <= '0;
    end else begin
      if (o_fifo_rd) begin
        r_word  <= i_fifo_data;
        r_widx  <= '0;
        r_valid <= 1'b1;
      end else if (word_end) begin
        r_word  <= r_word >> PW;
        r_widx  <= '0;
        r_valid <= 1'b0;
      end else if (accept) begin
        r_word  <= r_word >> PW;
        r_widx  <= r_widx + IW'(1);
      end

      if (line_end) begin
        r_xpos <= '0;
      end else if (accept) begin
        r_xpos <= r_xpos + LGLINE'(1);
      end

      // Length is sampled only at a line boundary: either idle at position 0, or
      // the cycle the last pixel of a line is taken (covers back-to-back lines).
      if (((r_xpos == '0) && !r_valid) || line_end) begin
        r_len <= i_line_pixels;
      end
    end
  end

endmodule

// File: tb/tb_fifo_pixel_unpack.sv
module tb_fifo_pixel_unpack;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_sync = 1'b0;
  logic [10:0] i_line_pixels = 11'd8;
  logic        i_fifo_empty = 1'b1;
  logic [31:0] i_fifo_data = '0;
  logic        o_fifo_rd;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [7:0]  o_pixel;
  logic        o_last;

  fifo_pixel_unpack #(.WW(32), .PW(8), .LGLINE(11)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_sync       (i_sync),
    .i_line_pixels(i_line_pixels),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_data  (i_fifo_data),
    .o_fifo_rd    (o_fifo_rd),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_pixel      (o_pixel),
    .o_last       (o_last)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0] px;
    logic       last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fq[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  int          rd_cnt = 0;
  int          rd0;
  logic        rd_s = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic refresh();
    i_fifo_empty = (fq.size() == 0);
    i_fifo_data  = (fq.size() != 0) ? fq[0] : 32'h0;
  endtask

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    refresh();
  endtask

  task automatic expect_px(input logic [7:0] p, input logic l);
    exp_t x;
    x.px   = p;
    x.last = l;
    exp_q.push_back(x);
  endtask

  // Advance one clock; the FIFO model pops on the edge where o_fifo_rd was high,
  // then presents the new head 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    if (rd_s && (fq.size() != 0)) void'(fq.pop_front());
    #1;
    refresh();
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    i_sync    = 1'b0;
    fq.delete();
    exp_q.delete();
    refresh();
    tick();
    tick();
    i_reset_n = 1'b1;
  endtask

  // Scoreboard monitor: compares every accepted pixel against the expected queue.
  always @(negedge i_clk) begin
    rd_s = o_fifo_rd;
    if (o_fifo_rd) rd_cnt++;
    if (o_valid && i_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pixel: got %0h last=%0b, no pixel expected", o_pixel, o_last);
      end else begin
        e = exp_q.pop_front();
        if ((o_pixel !== e.px) || (o_last !== e.last)) begin
          errors++;
          $display("FAIL pixel: got %0h last=%0b, want %0h last=%0b", o_pixel, o_last, e.px, e.last);
        end
      end
    end
  end

  initial begin
    // Reset state, with the FIFO non-empty so a pop would be visible.
    i_ready = 1'b1;
    tick();
    push(32'h44332211);
    #1;
    chk("rst_fifo_rd", o_fifo_rd, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_last", o_last, 0);
    chk("rst_pixel", o_pixel, 0);

    // Stream: two words, one 8-pixel line.
    i_line_pixels = 11'd8;
    do_reset();
    for (int i = 1; i <= 8; i++) expect_px(8'(i * 8'h11), i == 8);
    rd0 = rd_cnt;
    push(32'h44332211);
    push(32'h88776655);
    #1;
    chk("t1_rd_latency", o_fifo_rd, 1);
    chk("t1_valid_before", o_valid, 0);
    tick();
    chk("t1_first_valid", o_valid, 1);
    chk("t1_first_pixel", o_pixel, 32'h11);
    repeat (8) tick();
    chk("t1_valid_drop", o_valid, 0);
    chk("t1_pops", rd_cnt - rd0, 2);
    chk("t1_drained", exp_q.size(), 0);

    // Short line of 6: 77 and 88 discarded, next line starts at 99.
    i_line_pixels = 11'd6;
    do_reset();
    for (int i = 1; i <= 6; i++) expect_px(8'(i * 8'h11), i == 6);
    for (int i = 9; i <= 12; i++) expect_px(8'(i * 8'h11), 1'b0);
    rd0 = rd_cnt;
    push(32'h44332211);
    push(32'h88776655);
    push(32'hCCBBAA99);
    repeat (11) tick();
    chk("t2_valid_drop", o_valid, 0);
    chk("t2_pops", rd_cnt - rd0, 3);
    chk("t2_drained", exp_q.size(), 0);

    // Back-pressure while 22 is shown.
    i_line_pixels = 11'd8;
    do_reset();
    for (int i = 1; i <= 8; i++) expect_px(8'(i * 8'h11), i == 8);
    push(32'h44332211);
    push(32'h88776655);
    tick();
    tick();
    i_ready = 1'b0;
    rd0 = rd_cnt;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_pixel", o_pixel, 32'h22);
      chk("t3_hold_valid", o_valid, 1);
      chk("t3_hold_last", o_last, 0);
    end
    chk("t3_no_pop", rd_cnt - rd0, 0);
    i_ready = 1'b1;
    tick();
    chk("t3_resume_pixel", o_pixel, 32'h33);
    repeat (7) tick();
    chk("t3_valid_drop", o_valid, 0);
    chk("t3_drained", exp_q.size(), 0);

    // Underflow: one word, gap, then the rest of the line (position continues at 4).
    do_reset();
    for (int i = 1; i <= 4; i++) expect_px(8'(i * 8'h11), 1'b0);
    push(32'h44332211);
    repeat (5) tick();
    chk("t4_underflow_drop", o_valid, 0);
    repeat (4) tick();
    chk("t4_still_idle", o_valid, 0);
    for (int i = 5; i <= 8; i++) expect_px(8'(i * 8'h11), i == 8);
    push(32'h88776655);
    #1;
    chk("t4_rd_on_arrival", o_fifo_rd, 1);
    tick();
    chk("t4_restart_valid", o_valid, 1);
    chk("t4_restart_pixel", o_pixel, 32'h55);
    repeat (4) tick();
    chk("t4_valid_drop", o_valid, 0);
    chk("t4_drained", exp_q.size(), 0);

    // Sync after pixel 22: held word dropped, new line starts at 55.
    do_reset();
    expect_px(8'h11, 1'b0);
    expect_px(8'h22, 1'b0);
    for (int i = 5; i <= 12; i++) expect_px(8'(i * 8'h11), i == 12);
    push(32'h44332211);
    push(32'h88776655);
    push(32'hCCBBAA99);
    tick();
    tick();
    tick();
    i_ready = 1'b0;
    i_sync  = 1'b1;
    tick();
    chk("t5_sync_valid", o_valid, 0);
    #1;
    chk("t5_sync_blocks_pop", o_fifo_rd, 0);
    tick();
    i_sync  = 1'b0;
    i_ready = 1'b1;
    #1;
    chk("t5_rd_after_sync", o_fifo_rd, 1);
    tick();
    chk("t5_next_pixel", o_pixel, 32'h55);
    repeat (8) tick();
    chk("t5_valid_drop", o_valid, 0);
    chk("t5_drained", exp_q.size(), 0);

    // Asynchronous reset mid-line: held word lost, FIFO contents kept.
    do_reset();
    expect_px(8'h11, 1'b0);
    expect_px(8'h22, 1'b0);
    for (int i = 5; i <= 12; i++) expect_px(8'(i * 8'h11), i == 12);
    push(32'h44332211);
    push(32'h88776655);
    push(32'hCCBBAA99);
    tick();
    tick();
    tick();
    i_reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", o_valid, 0);
    chk("t6_rst_pixel", o_pixel, 0);
    chk("t6_rst_rd", o_fifo_rd, 0);
    tick();
    i_reset_n = 1'b1;
    #1;
    chk("t6_rd_after_rst", o_fifo_rd, 1);
    tick();
    chk("t6_next_pixel", o_pixel, 32'h55);
    repeat (8) tick();
    chk("t6_valid_drop", o_valid, 0);
    chk("t6_drained", exp_q.size(), 0);

    // Line length 8 -> 4 mid-line: current line ends at 8, next at 4.
    i_line_pixels = 11'd8;
    do_reset();
    for (int i = 1; i <= 8; i++) expect_px(8'(i * 8'h11), i == 8);
    for (int i = 9; i <= 12; i++) expect_px(8'(i * 8'h11), i == 12);
    rd0 = rd_cnt;
    push(32'h44332211);
    push(32'h88776655);
    push(32'hCCBBAA99);
    tick();
    tick();
    i_line_pixels = 11'd4;
    repeat (11) tick();
    chk("t7_valid_drop", o_valid, 0);
    chk("t7_pops", rd_cnt - rd0, 3);
    chk("t7_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
